// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: shared types and helpers for the UART transmit framer.
//   parity_mode_t : encoding of the parity_mode_i control (11 also means none)
//   tx_state_t    : framer FSM states; BREAK exists only when
//                   UART_TX_FRAMER_BREAK_EN is defined
//   bit_time()    : effective clocks per bit for a raw divider value
package uart_tx_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'b00,
        PAR_EVEN = 2'b01,
        PAR_ODD  = 2'b10
    } parity_mode_t;

`ifdef UART_TX_FRAMER_BREAK_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} tx_state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;
`endif

    // A divider of zero would stall the bit timer, so it is promoted to one.
    function automatic int unsigned bit_time(input int unsigned div);
        return (div == 0) ? 1 : div;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous FIFO buffering words ahead of the serialiser.
// Ports:
//   clk, srst      : clock, synchronous active-high reset (pointers only)
//   push, wdata    : write request and data (ignored when full unless popping)
//   pop, rdata     : read request; rdata shows the head entry
//   full, empty    : occupancy flags derived from the pointer registers
module uart_tx_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              push,
    input  logic [DATA_W-1:0] wdata,
    input  logic              pop,
    output logic [DATA_W-1:0] rdata,
    output logic              full,
    output logic              empty
);
    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra MSB so full and empty are distinguishable.
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              do_push;
    logic              do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A simultaneous pop frees a slot, so a push on a full FIFO is still safe.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/uart_tx_framer.sv
// uart_tx_framer: buffered, run-time configurable UART transmitter.
// Optional feature macro: UART_TX_FRAMER_BREAK_EN (adds break_i line-break control).
// Ports:
//   clk_i, srst_i   : clock, synchronous active-high reset
//   div_i           : clocks per bit (0 behaves as 1), latched at frame start
//   parity_mode_i   : 00 none, 01 even, 10 odd, 11 none; latched at frame start
//   stop2_i         : two stop bits when set; latched at frame start
//   data_i, valid_i : word and its valid; accepted when ready_o is high
//   break_i         : (macro only) hold the line low between frames
//   ready_o         : FIFO has space
//   tx_o            : serial output, idle high, LSB first
//   busy_o          : frame in progress or words queued
//   frame_done_o    : one-cycle pulse after the last stop bit
module uart_tx_framer
    import uart_tx_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_W      = 16
) (
    input  logic              clk_i,
    input  logic              srst_i,
    input  logic [DIV_W-1:0]  div_i,
    input  logic [1:0]        parity_mode_i,
    input  logic              stop2_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              valid_i,
`ifdef UART_TX_FRAMER_BREAK_EN
    input  logic              break_i,
`endif
    output logic              ready_o,
    output logic              tx_o,
    output logic              busy_o,
    output logic              frame_done_o
);
    localparam int BW = $clog2(DATA_W);

    tx_state_t         state;
    logic [DIV_W-1:0]  cnt;
    logic [DIV_W-1:0]  div_q;
    logic [DIV_W-1:0]  div_eff;
    logic [BW-1:0]     bit_idx;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] fifo_rdata;
    logic              par_bit;
    logic              par_en;
    logic              stop2_q;
    logic              stop_left;
    logic              tx_q;
    logic              done_q;
    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    logic              bit_end;
`ifdef UART_TX_FRAMER_BREAK_EN
    logic              brk_mark;
`endif

    uart_tx_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk_i),
        .srst  (srst_i),
        .push  (push),
        .wdata (data_i),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign push         = valid_i && !fifo_full;
    assign ready_o      = !fifo_full;
    assign busy_o       = (state != IDLE) || !fifo_empty;
    assign tx_o         = tx_q;
    assign frame_done_o = done_q;
    assign bit_end      = (cnt == '0);
    assign div_eff      = DIV_W'(bit_time(32'(div_i)));

    // Pop from IDLE, or directly at the end of the last stop bit so that
    // back-to-back frames have no idle gap between them.
    always_comb begin
        pop = !fifo_empty &&
              ((state == IDLE) || ((state == STOP) && bit_end && !stop_left));
`ifdef UART_TX_FRAMER_BREAK_EN
        if (break_i) pop = 1'b0;
`endif
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state     <= IDLE;
            tx_q      <= 1'b1;
            done_q    <= 1'b0;
            cnt       <= '0;
            bit_idx   <= '0;
            stop_left <= 1'b0;
`ifdef UART_TX_FRAMER_BREAK_EN
            brk_mark  <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    tx_q <= 1'b1;
`ifdef UART_TX_FRAMER_BREAK_EN
                    if (break_i) begin
                        state    <= BREAK;
                        tx_q     <= 1'b0;
                        brk_mark <= 1'b0;
                    end
`endif
                end
                START: begin
                    if (bit_end) begin
                        state   <= DATA;
                        tx_q    <= shreg[0];
                        shreg   <= shreg >> 1;
                        bit_idx <= '0;
                        cnt     <= div_q - 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        cnt <= div_q - 1'b1;
                        if (bit_idx == BW'(DATA_W - 1)) begin
                            if (par_en) begin
                                state <= PARITY;
                                tx_q  <= par_bit;
                            end else begin
                                state     <= STOP;
                                tx_q      <= 1'b1;
                                stop_left <= stop2_q;
                            end
                        end else begin
                            tx_q    <= shreg[0];
                            shreg   <= shreg >> 1;
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        state     <= STOP;
                        tx_q      <= 1'b1;
                        stop_left <= stop2_q;
                        cnt       <= div_q - 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        if (stop_left) begin
                            stop_left <= 1'b0;
                            cnt       <= div_q - 1'b1;
                        end else begin
                            done_q <= 1'b1;
                            state  <= IDLE;
                            tx_q   <= 1'b1;
`ifdef UART_TX_FRAMER_BREAK_EN
                            if (break_i) begin
                                state    <= BREAK;
                                tx_q     <= 1'b0;
                                brk_mark <= 1'b0;
                            end
`endif
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
`ifdef UART_TX_FRAMER_BREAK_EN
                // Line held low while break_i is high; on release, one full
                // bit time of mark is sent before IDLE may start a new frame.
                BREAK: begin
                    if (!brk_mark) begin
                        tx_q <= 1'b0;
                        if (!break_i) begin
                            brk_mark <= 1'b1;
                            tx_q     <= 1'b1;
                            cnt      <= div_eff - 1'b1;
                        end
                    end else if (bit_end) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
`endif
                default: state <= IDLE;
            endcase

            // Frame start overrides the per-state updates above.
            if (pop) begin
                state   <= START;
                tx_q    <= 1'b0;
                div_q   <= div_eff;
                cnt     <= div_eff - 1'b1;
                shreg   <= fifo_rdata;
                par_en  <= (parity_mode_i == PAR_EVEN) || (parity_mode_i == PAR_ODD);
                par_bit <= (parity_mode_i == PAR_ODD) ? ~^fifo_rdata : ^fifo_rdata;
                stop2_q <= stop2_i;
            end
        end
    end

endmodule

// File: doc/uart_tx_framer.md
Name: uart_tx_framer

Overview:
- Parametrised UART transmit framer for the sigma debug/stimulus path; successor to the single fixed-format byte-serial driver.
- Accepts data words over a valid/ready handshake into an internal FIFO and serialises them on tx_o.
- Baud divider, parity mode and stop-bit count are run-time configurable; data width and FIFO depth are compile-time parameters.
- Sits in front of any UDM-style receiver: its tx_o drives the receiver's rx input.

Parameters:
- DATA_W, 8, data bits per frame (5..9), sent LSB first.
- FIFO_DEPTH, 4, transmit buffer entries; power of two, minimum 2.
- DIV_W, 16, width of the run-time baud divider.

Ports:
- clk_i  in  1  system clock
- srst_i  in  1  synchronous reset, active-high
- div_i  in  DIV_W  clocks per bit; value 0 treated as 1
- parity_mode_i  in  2  00 none, 01 even, 10 odd, 11 none
- stop2_i  in  1  0: one stop bit, 1: two stop bits
- data_i  in  DATA_W  word to send
- valid_i  in  1  data_i valid
- ready_o  out  1  FIFO not full
- tx_o  out  1  serial line, idle high
- busy_o  out  1  frame in progress or FIFO non-empty
- frame_done_o  out  1  one-cycle pulse at end of last stop bit

Behaviour:
- Reset (srst_i sampled high at a clock edge): tx_o=1, ready_o=1, busy_o=0, frame_done_o=0, FIFO emptied, FSM in IDLE. Applies mid-frame: tx_o returns to 1 the cycle after reset is sampled, and the partial frame is discarded.
- Handshake: push occurs when valid_i && ready_o at a clock edge. ready_o = !full, registered. A push and a pop in the same cycle on a full FIFO are both allowed; count is unchanged.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: if the FIFO is non-empty, pop the word and latch div, parity_mode and stop2 into frame registers. Go to START; tx_o=0 from the next cycle.
  - START: one bit time with tx_o=0, then go to DATA.
  - DATA: DATA_W bit times, LSB first, using a shift register and a bit counter. When done, go to PARITY if parity is enabled, otherwise go to STOP.
  - PARITY: one bit time. Even mode sends XOR of the data bits; odd mode sends its inverse.
  - STOP: tx_o=1 for one bit time, or two if stop2 is latched. At the end, pulse frame_done_o and go to IDLE.
- Bit time is exactly latched div clocks. The counter loads div-1 at each bit start, decrements, and advances when it reaches 0.
- Back-to-back frames: if the FIFO is non-empty when STOP ends, the IDLE pop happens in that same cycle. The next start bit follows the last stop bit with zero idle cycles. One frame therefore takes exactly div*(1+DATA_W+P+S) clocks, where P is the parity bit count and S the stop bit count.
- Changing div_i, parity_mode_i or stop2_i mid-frame has no effect until the next frame start.
- busy_o = (state != IDLE) || !empty.
- FIFO pointers are log2(FIFO_DEPTH)+1 bits, with the extra MSB used for full/empty detection; they wrap modulo 2*FIFO_DEPTH.

Optional Feature:
- Macro: UART_TX_FRAMER_BREAK_EN.
- When defined: adds input break_i (1 bit).
  - While break_i is high in IDLE, tx_o is held 0 and no pop occurs.
  - If break_i rises mid-frame, the current frame completes first, then the break begins.
  - Releasing break_i returns to IDLE with tx_o=1 and a minimum of one bit time of mark before the next start bit.
- When not defined: no break_i port and no break logic.

Decomposition:
- Package uart_tx_pkg:
  - enum parity_mode_t (PAR_NONE, PAR_EVEN, PAR_ODD).
  - enum tx_state_t (IDLE, START, DATA, PARITY, STOP, plus BREAK under the macro).
  - Bit-time count helper function.
- Sub-module uart_tx_fifo: synchronous FIFO parametrised by width and depth, with push/pop/full/empty. It is the only natural split; the FSM and bit timer stay in uart_tx_framer.

Test Plan:
- Basic frame: DATA_W=8, div=4, parity none, stop2=0, push 0xA5 → tx_o levels 0,1,0,1,0,0,1,0,1,1, each held 4 clocks; frame_done_o pulses once, 40 clocks after start; busy_o falls the cycle after.
- Parity: div=2, push 0xA5 (four ones) with even parity → parity bit 0, frame 22 clocks. Same word with odd parity → parity bit 1. Push 0x07 with even parity → parity bit 1.
- FIFO full and back-to-back: FIFO_DEPTH=4, div=3, stop2=1; push 6 words with valid_i held high. Expect:
  - ready_o drops after the FIFO fills (5 words accepted while the first is sending).
  - The 6th word is accepted once space frees.
  - All 6 frames emitted with no idle gap, each 33 clocks.
- Config change mid-frame: start a frame with div=4, switch to div=8 during DATA → current frame keeps 4-clock bits; the next frame uses 8-clock bits.
- Reset mid-frame: assert srst_i during bit 3 of 0x3C → tx_o=1 and ready_o=1 the next cycle, busy_o=0, no frame_done_o pulse, queued words discarded.
- div=0 → behaves as div=1: an 8N1 frame lasts 10 clocks.
